dmem_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port DataMemory between the N SP cores of one SMCore. Each core issues at most one load or store at a time through a level request / pulse done handshake. The arbiter serialises the requests onto the memory port and returns read data per core. It sits between the N_SPCores load/store paths and DataMemory, and its `busy` output lets the CU stall.

---
 rtl/tinygpu_mem_pkg.sv | 13 +
 rtl/dmem_rr_pick.sv | 33 +++
 rtl/dmem_rr_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_rr_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinygpu_mem_pkg.sv
// Shared types and defaults for the tinygpu data-memory path.
package tinygpu_mem_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} dmem_arb_state_e;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, with wrap.
module dmem_rr_pick
    import tinygpu_mem_pkg::*;
#(
    parameter int unsigned N_CORES = 4,
    localparam int unsigned IDX_W = idx_width(N_CORES)
) (
    input  logic [N_CORES-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan from the farthest offset down so the nearest requester wins last.
        for (int k = int'(N_CORES) - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_CORES)) begin
                cand = cand - (IDX_W + 1)'(N_CORES);
            end
            if (req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing single-port DataMemory between SP cores.
// Optional DMEM_ARB_READ_MERGE_EN: same-address loads complete together.
module dmem_rr_arbiter
    import tinygpu_mem_pkg::*;
#(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        req,
    input  logic [N_CORES-1:0]        we,
    input  logic [N_CORES*ADDR_W-1:0] addr,
    input  logic [N_CORES*DATA_W-1:0] wdata,
    output logic [N_CORES-1:0]        done,
    output logic [N_CORES*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int unsigned IDX_W = idx_width(N_CORES);

    dmem_arb_state_e state_q, state_d;

    logic [IDX_W-1:0]          ptr_q, g_q, pick_idx;
    logic                      pick_valid, we_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [N_CORES*DATA_W-1:0] rdata_q;
    logic [N_CORES-1:0]        grant_oh, served;

    dmem_rr_pick #(
        .N_CORES(N_CORES)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pick_valid) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_oh      = '0;
        grant_oh[g_q] = 1'b1;
        served        = grant_oh;
`ifdef DMEM_ARB_READ_MERGE_EN
        if (!we_q) begin
            for (int i = 0; i < int'(N_CORES); i++) begin
                if (req[i] && !we[i] && addr[i*ADDR_W +: ADDR_W] == addr_q) begin
                    served[i] = 1'b1;
                end
            end
        end
`endif
        done   = (state_q == StResp) ? served : '0;
        mem_we = (state_q == StIssue) && we_q;
        // Load data bypasses to rdata in the done cycle and is held by rdata_q afterwards.
        rdata  = rdata_q;
        for (int i = 0; i < int'(N_CORES); i++) begin
            if (done[i] && !we_q) begin
                rdata[i*DATA_W +: DATA_W] = mem_rdata;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle) || (|req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            g_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == StIdle && pick_valid) begin
                g_q     <= pick_idx;
                we_q    <= we[pick_idx];
                addr_q  <= addr[pick_idx*ADDR_W +: ADDR_W];
                wdata_q <= wdata[pick_idx*DATA_W +: DATA_W];
            end
            if (state_q == StResp) begin
                ptr_q <= (g_q == IDX_W'(N_CORES - 1)) ? '0 : g_q + 1'b1;
            end
            rdata_q <= rdata;
        end
    end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: cycle-level reference model plus directed literal checks.
module tb_dmem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, we, done;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata, rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic            mem_we, busy;

    logic            pre_we;
    logic [AW-1:0]   pre_addr;
    logic [DW-1:0]   pre_data;
    logic [DW-1:0]   ram [0:65535];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int gorder[$];
    int gcyc[$];
    int again[N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_rr_arbiter #(
        .N_CORES(N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .done     (done),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    // Synchronous-read single-port RAM standing in for DataMemory.
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_phase = 0;  // 0 waiting, 1 memory cycle, 2 response cycle
    int            m_g = 0;
    int            m_ptr = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0, m_maddr = '0;
    logic [DW-1:0] m_wdata = '0, m_mwdata = '0, m_val = '0;
    logic [DW-1:0] m_rd [N];
    logic [DW-1:0] gram [0:65535];
    logic [N-1:0]  e_done;
    logic [N*DW-1:0] e_rdata;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ((i - p + N) % N) < bd) begin
                bd = (i - p + N) % N;
                best = i;
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        if (pre_we) gram[pre_addr] = pre_data;
        if (!reset) begin
            m_phase = 0;
            m_ptr = 0;
            m_maddr = '0;
            m_mwdata = '0;
            for (int i = 0; i < N; i++) m_rd[i] = '0;
        end
        e_done = '0;
        if (m_phase == 2) begin
            e_done[m_g] = 1'b1;
`ifdef DMEM_ARB_READ_MERGE_EN
            if (!m_we) begin
                for (int i = 0; i < N; i++) begin
                    if (req[i] && !we[i] && addr[i*AW +: AW] == m_addr) e_done[i] = 1'b1;
                end
            end
`endif
        end
        for (int i = 0; i < N; i++) begin
            e_rdata[i*DW +: DW] = (e_done[i] && !m_we) ? m_val : m_rd[i];
        end
        chk("model_done", done, e_done);
        chk("model_rdata", rdata, e_rdata);
        chk("model_mem_we", mem_we, (m_phase == 1) && m_we);
        chk("model_mem_addr", mem_addr, m_maddr);
        chk("model_mem_wdata", mem_wdata, m_mwdata);
        chk("model_busy", busy, (m_phase != 0) || (|req));
        if (m_phase != 0) chk("protocol_req_held", req[m_g], 1'b1);
        if (reset) begin
            case (m_phase)
                0: if (|req) begin
                    m_g = rr_pick(req, m_ptr);
                    m_we = we[m_g];
                    m_addr = addr[m_g*AW +: AW];
                    m_wdata = wdata[m_g*DW +: DW];
                    m_maddr = m_addr;
                    m_mwdata = m_wdata;
                    m_phase = 1;
                end
                1: begin
                    if (m_we) gram[m_addr] = m_wdata;
                    else m_val = gram[m_addr];
                    m_phase = 2;
                end
                default: begin
                    for (int i = 0; i < N; i++) if (e_done[i] && !m_we) m_rd[i] = m_val;
                    m_ptr = (m_g + 1) % N;
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic raise(input int c, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req[c] = 1'b1;
        we[c] = w;
        addr[c*AW +: AW] = a;
        wdata[c*DW +: DW] = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    // Drops each req after its done; again[i] re-raises core i one cycle later.
    task automatic serve(input int budget);
        logic [N-1:0] clr;
        logic [N-1:0] rearm;
        int k;
        gorder.delete();
        gcyc.delete();
        rearm = '0;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            clr = done;
            for (int i = 0; i < N; i++) begin
                if (clr[i]) begin
                    gorder.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
            @(posedge clk); #1;
            req = (req & ~clr) | rearm;
            rearm = '0;
            for (int i = 0; i < N; i++) begin
                if (clr[i] && again[i] > 0) begin
                    again[i]--;
                    rearm[i] = 1'b1;
                end
            end
            if (req == '0 && rearm == '0) break;
        end
        chk("serve_in_budget", k < budget, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b0;
        req = '0;
        we = '0;
        addr = '0;
        wdata = '0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        for (int i = 0; i < N; i++) again[i] = 0;

        preload(16'h0010, 16'hBEEF);
        preload(16'h0030, 16'h0303);
        preload(16'h0040, 16'h00AA);

        // Reset values; busy follows req while in reset.
        @(negedge clk);
        chk("reset_done", done, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_busy_idle", busy, 0);
        @(posedge clk); #1;
        req = 4'b0010;
        @(negedge clk);
        chk("reset_busy_req", busy, 1);
        @(posedge clk); #1;
        req = '0;
        reset = 1'b1;
        gap();

        // All four cores at once from ptr 0.
        raise(0, 1'b0, 16'h0010, 16'h0);
        raise(1, 1'b1, 16'h0050, 16'h1111);
        raise(2, 1'b0, 16'h0040, 16'h0);
        raise(3, 1'b0, 16'h0030, 16'h0);
        t = cyc;
        serve(60);
        chk("all4_count", gorder.size(), 4);
        if (gorder.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk("all4_order", gorder[j], j);
                chk("all4_done_cycle", gcyc[j], t + 2 + 3 * j);
            end
        end
        chk("all4_rdata0", rdata[0 +: 16], 16'hBEEF);
        chk("all4_rdata2", rdata[32 +: 16], 16'h00AA);
        chk("all4_rdata3", rdata[48 +: 16], 16'h0303);

        // ptr wrapped to 0: core 0 beats core 3.
        gap();
        raise(0, 1'b0, 16'h0010, 16'h0);
        raise(3, 1'b0, 16'h0030, 16'h0);
        serve(30);
        chk("wrap_count", gorder.size(), 2);
        if (gorder.size() == 2) begin
            chk("wrap_first", gorder[0], 0);
            chk("wrap_second", gorder[1], 3);
        end

        // Single load by core 2.
        gap();
        raise(2, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        chk("ld_t0_mem_we", mem_we, 0);
        @(negedge clk);
        chk("ld_t1_mem_we", mem_we, 0);
        chk("ld_t1_mem_addr", mem_addr, 16'h0010);
        chk("ld_t1_done", done, 0);
        @(negedge clk);
        chk("ld_t2_done", done, 4'b0100);
        chk("ld_t2_rdata2", rdata[32 +: 16], 16'hBEEF);
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(negedge clk);
        chk("ld_t3_done", done, 0);
        chk("ld_t3_rdata_hold", rdata[32 +: 16], 16'hBEEF);
        chk("ld_t3_busy", busy, 0);

        // Single store by core 0.
        gap();
        raise(0, 1'b1, 16'h0020, 16'h1234);
        @(negedge clk);
        chk("st_t0_mem_we", mem_we, 0);
        @(negedge clk);
        chk("st_t1_mem_we", mem_we, 1);
        chk("st_t1_mem_addr", mem_addr, 16'h0020);
        chk("st_t1_mem_wdata", mem_wdata, 16'h1234);
        @(negedge clk);
        chk("st_t2_mem_we", mem_we, 0);
        chk("st_t2_done", done, 4'b0001);
        chk("st_t2_rdata0_kept", rdata[0 +: 16], 16'hBEEF);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("st_ram", ram[16'h0020], 16'h1234);

        // ptr=1: core 2 must precede core 0.
        gap();
        raise(0, 1'b0, 16'h0010, 16'h0);
        raise(2, 1'b0, 16'h0040, 16'h0);
        serve(30);
        chk("rot_count", gorder.size(), 2);
        if (gorder.size() == 2) begin
            chk("rot_first", gorder[0], 2);
            chk("rot_second", gorder[1], 0);
        end

        // Fairness: core 3 alone, then core 0 twice against core 1 once.
        gap();
        raise(3, 1'b0, 16'h0030, 16'h0);
        serve(20);
        chk("fair_pre_count", gorder.size(), 1);
        if (gorder.size() == 1) chk("fair_pre_core", gorder[0], 3);
        gap();
        again[0] = 1;
        raise(0, 1'b0, 16'h0010, 16'h0);
        raise(1, 1'b0, 16'h0030, 16'h0);
        serve(40);
        chk("fair_count", gorder.size(), 3);
        if (gorder.size() == 3) begin
            chk("fair_g0", gorder[0], 0);
            chk("fair_g1", gorder[1], 1);
            chk("fair_g2", gorder[2], 0);
        end

        // Core 2 reads back the stored word.
        gap();
        raise(2, 1'b0, 16'h0020, 16'h0);
        serve(20);
        chk("readback_rdata2", rdata[32 +: 16], 16'h1234);

        // Reset during the memory cycle of a store.
        gap();
        raise(1, 1'b1, 16'h0030, 16'h5555);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_we", mem_we, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_busy", busy, 1);
        @(posedge clk); #1;
        req = '0;
        we = '0;
        @(negedge clk);
        chk("rst_mid_busy_idle", busy, 0);
        chk("rst_mid_rdata", rdata, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_done", done, 0);
        end
        chk("rst_mid_ram", ram[16'h0030], 16'h0303);

        // ptr back at 0 after reset: core 0 beats core 3.
        gap();
        raise(3, 1'b0, 16'h0030, 16'h0);
        raise(0, 1'b0, 16'h0010, 16'h0);
        serve(30);
        chk("post_rst_count", gorder.size(), 2);
        if (gorder.size() == 2) begin
            chk("post_rst_first", gorder[0], 0);
            chk("post_rst_second", gorder[1], 3);
        end
        chk("post_rst_rdata0", rdata[0 +: 16], 16'hBEEF);
        chk("post_rst_rdata3", rdata[48 +: 16], 16'h0303);

        // Cores 1 and 3 load the same address together.
        gap();
        raise(1, 1'b0, 16'h0040, 16'h0);
        raise(3, 1'b0, 16'h0040, 16'h0);
        t = cyc;
        serve(30);
        chk("same_addr_count", gorder.size(), 2);
        if (gorder.size() == 2) begin
            chk("same_addr_g0", gorder[0], 1);
            chk("same_addr_g1", gorder[1], 3);
            chk("same_addr_t0", gcyc[0], t + 2);
`ifdef DMEM_ARB_READ_MERGE_EN
            chk("same_addr_t1", gcyc[1], t + 2);
`else
            chk("same_addr_t1", gcyc[1], t + 5);
`endif
        end
        chk("same_addr_rdata1", rdata[16 +: 16], 16'h00AA);
        chk("same_addr_rdata3", rdata[48 +: 16], 16'h00AA);

        gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
